// File: rtl/control_unit_if.sv
// Control bus between the multicycle control FSM and the datapath:
// decoded IR fields and ALU flags in, every datapath enable/select out.
interface control_unit_if #(
    parameter int FUNCT_W = 6
);
    logic [5:0]         opcode;
    logic [FUNCT_W-1:0] funct;
    logic               Overflow;
    logic               Zero;

    logic               PC_write;
    logic               IRWrite;
    logic               A_write;
    logic               B_write;
    logic               ALUOut_write;
    logic               MDR_write;
    logic               EPC_write;
    logic               RegWrite;
    logic               MemWrite;
    logic               IorD;
    logic               RegDst;
    logic               MemtoReg;
    logic               seletor_ulaA;
    logic [1:0]         seletor_ulaB;
    logic [2:0]         Seletor;
    logic [1:0]         PCSource;
    logic [4:0]         state_dbg;

    // Control unit side
    modport master (
        input  opcode, funct, Overflow, Zero,
        output PC_write, IRWrite, A_write, B_write, ALUOut_write, MDR_write,
               EPC_write, RegWrite, MemWrite, IorD, RegDst, MemtoReg,
               seletor_ulaA, seletor_ulaB, Seletor, PCSource, state_dbg
    );

    // Datapath side
    modport slave (
        output opcode, funct, Overflow, Zero,
        input  PC_write, IRWrite, A_write, B_write, ALUOut_write, MDR_write,
               EPC_write, RegWrite, MemWrite, IorD, RegDst, MemtoReg,
               seletor_ulaA, seletor_ulaB, Seletor, PCSource, state_dbg
    );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath (add/sub/and, addi,
// lw, sw, beq, bne, j). Outputs are decoded from the registered state, with
// a few Mealy terms (branch condition, funct/overflow in R_EXEC).
module control_unit #(
    parameter int MEM_WAIT = 1,
    parameter int FUNCT_W  = 6
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    typedef enum logic [4:0] {
        S_RST         = 5'd0,
        S_FETCH       = 5'd1,
        S_MEMWAIT_F   = 5'd2,
        S_FETCH_LATCH = 5'd3,
        S_DECODE      = 5'd4,
        S_R_EXEC      = 5'd5,
        S_R_WB        = 5'd6,
        S_ADDI_EXEC   = 5'd7,
        S_ADDI_WB     = 5'd8,
        S_ADDR        = 5'd9,
        S_LW_READ     = 5'd10,
        S_MEMWAIT_L   = 5'd11,
        S_LW_MDR      = 5'd12,
        S_LW_WB       = 5'd13,
        S_SW_WRITE    = 5'd14,
        S_BRANCH      = 5'd15,
        S_JUMP        = 5'd16,
        S_EXC_EPC     = 5'd17,
        S_EXC_PC      = 5'd18
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'h20);
    localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'h22);
    localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'h24);

    // Counter reload value: MEMWAIT_* lasts exactly MEM_WAIT cycles
    localparam logic [1:0] WAIT_LOAD = 2'(MEM_WAIT - 1);

    state_t     state, nxt;
    logic [1:0] cnt;

    // State register and memory wait counter; reset clears both at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= nxt;
            case (state)
                S_FETCH, S_LW_READ:       cnt <= WAIT_LOAD;
                S_MEMWAIT_F, S_MEMWAIT_L: if (cnt != 2'd0) cnt <= cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // Next-state and control decode; everything defaults to 0
    always_comb begin
        nxt              = S_RST;
        bus.PC_write     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.A_write      = 1'b0;
        bus.B_write      = 1'b0;
        bus.ALUOut_write = 1'b0;
        bus.MDR_write    = 1'b0;
        bus.EPC_write    = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IorD         = 1'b0;
        bus.RegDst       = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.seletor_ulaA = 1'b0;
        bus.seletor_ulaB = 2'b00;
        bus.Seletor      = 3'b000;
        bus.PCSource     = 2'b00;
        case (state)
            S_RST:   nxt = S_FETCH;
            S_FETCH: begin
                bus.IorD = 1'b0;
                nxt      = S_MEMWAIT_F;
            end
            S_MEMWAIT_F: nxt = (cnt == 2'd0) ? S_FETCH_LATCH : S_MEMWAIT_F;
            S_FETCH_LATCH: begin
                // PC <= PC + 4 while IR latches
                bus.IRWrite      = 1'b1;
                bus.seletor_ulaB = 2'b01;
                bus.Seletor      = 3'b001;
                bus.PC_write     = 1'b1;
                nxt              = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                bus.A_write      = 1'b1;
                bus.B_write      = 1'b1;
                bus.seletor_ulaB = 2'b11;
                bus.Seletor      = 3'b001;
                bus.ALUOut_write = 1'b1;
                case (bus.opcode)
                    OP_R:          nxt = S_R_EXEC;
                    OP_ADDI:       nxt = S_ADDI_EXEC;
                    OP_LW, OP_SW:  nxt = S_ADDR;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_J:          nxt = S_JUMP;
                    default:       nxt = S_EXC_EPC;
                endcase
            end
            S_R_EXEC: begin
                bus.seletor_ulaA = 1'b1;
                bus.seletor_ulaB = 2'b00;
                case (bus.funct)
                    F_ADD: begin
                        bus.Seletor      = 3'b001;
                        bus.ALUOut_write = 1'b1;
                        nxt = bus.Overflow ? S_EXC_EPC : S_R_WB;
                    end
                    F_SUB: begin
                        bus.Seletor      = 3'b010;
                        bus.ALUOut_write = 1'b1;
                        nxt = bus.Overflow ? S_EXC_EPC : S_R_WB;
                    end
                    F_AND: begin
                        // Logical op: overflow flag is meaningless here
                        bus.Seletor      = 3'b011;
                        bus.ALUOut_write = 1'b1;
                        nxt = S_R_WB;
                    end
                    default: nxt = S_EXC_EPC;
                endcase
            end
            S_R_WB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                nxt          = S_FETCH;
            end
            S_ADDI_EXEC: begin
                bus.seletor_ulaA = 1'b1;
                bus.seletor_ulaB = 2'b10;
                bus.Seletor      = 3'b001;
                bus.ALUOut_write = 1'b1;
                nxt = bus.Overflow ? S_EXC_EPC : S_ADDI_WB;
            end
            S_ADDI_WB: begin
                bus.RegWrite = 1'b1;
                nxt          = S_FETCH;
            end
            S_ADDR: begin
                bus.seletor_ulaA = 1'b1;
                bus.seletor_ulaB = 2'b10;
                bus.Seletor      = 3'b001;
                bus.ALUOut_write = 1'b1;
                nxt = (bus.opcode == OP_SW) ? S_SW_WRITE : S_LW_READ;
            end
            S_LW_READ: begin
                bus.IorD = 1'b1;
                nxt      = S_MEMWAIT_L;
            end
            S_MEMWAIT_L: nxt = (cnt == 2'd0) ? S_LW_MDR : S_MEMWAIT_L;
            S_LW_MDR: begin
                bus.MDR_write = 1'b1;
                nxt           = S_LW_WB;
            end
            S_LW_WB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                nxt          = S_FETCH;
            end
            S_SW_WRITE: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                nxt          = S_FETCH;
            end
            S_BRANCH: begin
                // Compare A-B; branch target already sits in ALUOut
                bus.seletor_ulaA = 1'b1;
                bus.seletor_ulaB = 2'b00;
                bus.Seletor      = 3'b010;
                bus.PCSource     = 2'b01;
                bus.PC_write     = (bus.opcode == OP_BEQ) ? bus.Zero : ~bus.Zero;
                nxt              = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSource = 2'b10;
                bus.PC_write = 1'b1;
                nxt          = S_FETCH;
            end
            S_EXC_EPC: begin
                // PC was already advanced; EPC <= PC - 4 points at the culprit
                bus.seletor_ulaB = 2'b01;
                bus.Seletor      = 3'b010;
                bus.EPC_write    = 1'b1;
                nxt              = S_EXC_PC;
            end
            S_EXC_PC: begin
                bus.PCSource = 2'b11;
                bus.PC_write = 1'b1;
                nxt          = S_FETCH;
            end
            default: nxt = S_RST;
        endcase
    end

    assign bus.state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the hand-derived
// per-cycle state/control trace, a negedge monitor pops and compares.
module tb_control_unit;

    localparam int MW = 2;

    localparam logic [4:0] S_RST = 5'd0,  S_FETCH = 5'd1,  S_MWF = 5'd2,
                           S_LATCH = 5'd3, S_DECODE = 5'd4, S_REX = 5'd5,
                           S_RWB = 5'd6,  S_AEX = 5'd7,    S_AWB = 5'd8,
                           S_ADDR = 5'd9, S_LWR = 5'd10,   S_MWL = 5'd11,
                           S_MDR = 5'd12, S_LWB = 5'd13,   S_SW = 5'd14,
                           S_BR = 5'd15,  S_J = 5'd16,     S_EPC = 5'd17,
                           S_EPC2 = 5'd18;

    typedef struct packed {
        logic [4:0] st;
        logic       pcw, irw, aw, bw, aluw, mdrw, epcw, regw, memw;
        logic       iord, regdst, m2r, ulaa;
        logic [1:0] ulab;
        logic [2:0] sel;
        logic [1:0] pcsrc;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;
    ctrl_t q[$];

    control_unit_if #(.FUNCT_W(6)) bus();

    control_unit #(.MEM_WAIT(MW), .FUNCT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t mk(input logic [4:0] st);
        ctrl_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    function automatic ctrl_t sample();
        ctrl_t g;
        g.st = bus.state_dbg;       g.pcw = bus.PC_write;
        g.irw = bus.IRWrite;        g.aw = bus.A_write;
        g.bw = bus.B_write;         g.aluw = bus.ALUOut_write;
        g.mdrw = bus.MDR_write;     g.epcw = bus.EPC_write;
        g.regw = bus.RegWrite;      g.memw = bus.MemWrite;
        g.iord = bus.IorD;          g.regdst = bus.RegDst;
        g.m2r = bus.MemtoReg;       g.ulaa = bus.seletor_ulaA;
        g.ulab = bus.seletor_ulaB;  g.sel = bus.Seletor;
        g.pcsrc = bus.PCSource;
        return g;
    endfunction

    // Monitor: every cycle with a pending expectation is one comparison
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ctrl_t e, g;
            e = q.pop_front();
            g = sample();
            n_checks++;
            step++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL trace step %0d: state got %0d need %0d, ctrl got %h need %h",
                         step, g.st, e.st, g, e);
            end
        end
    end

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: queue depth got %0d need 0", q.size());
            q.delete();
        end
    endtask

    // Start an instruction: DUT is in FETCH one tick after the next posedge
    task automatic start(input logic [5:0] op, input logic [5:0] fn,
                         input logic ovf, input logic z);
        ctrl_t c;
        wait_empty();
        @(posedge clk); #1;
        bus.opcode = op; bus.funct = fn; bus.Overflow = ovf; bus.Zero = z;
        q.push_back(mk(S_FETCH));
        for (int i = 0; i < MW; i++) q.push_back(mk(S_MWF));
        c = mk(S_LATCH); c.irw = 1; c.ulab = 2'b01; c.sel = 3'b001; c.pcw = 1;
        q.push_back(c);
        c = mk(S_DECODE); c.aw = 1; c.bw = 1; c.ulab = 2'b11; c.sel = 3'b001;
        c.aluw = 1;
        q.push_back(c);
    endtask

    task automatic push_exc();
        ctrl_t c;
        c = mk(S_EPC); c.ulab = 2'b01; c.sel = 3'b010; c.epcw = 1;
        q.push_back(c);
        c = mk(S_EPC2); c.pcsrc = 2'b11; c.pcw = 1;
        q.push_back(c);
    endtask

    task automatic push_rexec(input logic [2:0] sel, input logic aluw);
        ctrl_t c;
        c = mk(S_REX); c.ulaa = 1; c.sel = sel; c.aluw = aluw;
        q.push_back(c);
    endtask

    task automatic push_rwb();
        ctrl_t c;
        c = mk(S_RWB); c.regdst = 1; c.regw = 1;
        q.push_back(c);
    endtask

    task automatic push_ea(input logic [4:0] st);
        ctrl_t c;
        c = mk(st); c.ulaa = 1; c.ulab = 2'b10; c.sel = 3'b001; c.aluw = 1;
        q.push_back(c);
    endtask

    task automatic branch(input logic [5:0] op, input logic z, input logic take);
        ctrl_t c;
        start(op, 6'h00, 1'b0, z);
        c = mk(S_BR); c.ulaa = 1; c.sel = 3'b010; c.pcsrc = 2'b01; c.pcw = take;
        q.push_back(c);
    endtask

    initial begin
        ctrl_t c;
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.Overflow = 1'b0; bus.Zero = 1'b0;
        reset = 1'b0;
        // Reset held three cycles: RST with every control low
        repeat (3) q.push_back(mk(S_RST));
        wait_empty();
        reset = 1'b1;

        // add, no overflow
        start(6'h00, 6'h20, 1'b0, 1'b0);
        push_rexec(3'b001, 1'b1); push_rwb();
        // sub with overflow: ALUOut written, no RegWrite, trap
        start(6'h00, 6'h22, 1'b1, 1'b0);
        push_rexec(3'b010, 1'b1); push_exc();
        // and ignores overflow
        start(6'h00, 6'h24, 1'b1, 1'b0);
        push_rexec(3'b011, 1'b1); push_rwb();
        // invalid funct: no ALUOut write, trap
        start(6'h00, 6'h25, 1'b0, 1'b0);
        push_rexec(3'b000, 1'b0); push_exc();
        // addi normal
        start(6'h08, 6'h00, 1'b0, 1'b0);
        push_ea(S_AEX);
        c = mk(S_AWB); c.regw = 1; q.push_back(c);
        // addi overflow
        start(6'h08, 6'h00, 1'b1, 1'b0);
        push_ea(S_AEX); push_exc();
        // lw: MW wait cycles, MemWrite stays low throughout
        start(6'h23, 6'h00, 1'b0, 1'b0);
        push_ea(S_ADDR);
        c = mk(S_LWR); c.iord = 1; q.push_back(c);
        for (int i = 0; i < MW; i++) q.push_back(mk(S_MWL));
        c = mk(S_MDR); c.mdrw = 1; q.push_back(c);
        c = mk(S_LWB); c.m2r = 1; c.regw = 1; q.push_back(c);
        // beq / bne with both Zero polarities
        branch(6'h04, 1'b1, 1'b1);
        branch(6'h04, 1'b0, 1'b0);
        branch(6'h05, 1'b1, 1'b0);
        branch(6'h05, 1'b0, 1'b1);
        // jump
        start(6'h02, 6'h00, 1'b0, 1'b0);
        c = mk(S_J); c.pcsrc = 2'b10; c.pcw = 1; q.push_back(c);
        // illegal opcode traps straight from DECODE
        start(6'h3F, 6'h00, 1'b0, 1'b0);
        push_exc();
        // sw, then reset asserted mid SW_WRITE cycle
        start(6'h2B, 6'h00, 1'b0, 1'b0);
        push_ea(S_ADDR);
        c = mk(S_SW); c.iord = 1; c.memw = 1; q.push_back(c);
        wait_empty();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.MemWrite !== 1'b0 || bus.state_dbg !== S_RST) begin
            n_fail++;
            $display("FAIL async reset in SW_WRITE: MemWrite got %b need 0, state got %0d need %0d",
                     bus.MemWrite, bus.state_dbg, S_RST);
        end
        q.push_back(mk(S_RST));
        wait_empty();
        reset = 1'b1;
        // recovery: RST -> FETCH, then a plain add completes
        start(6'h00, 6'h20, 1'b0, 1'b0);
        push_rexec(3'b001, 1'b1); push_rwb();
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: sim time got %0t need completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
